// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter between the core and an external host; the host
// gets bounded bursts while the core waits, unless it holds ext_lock.
module dmem_arbiter #(
  parameter int unsigned EXT_BURST = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic [31:0] core_rdata,
  output logic        core_stall,
  input  logic        ext_req,
  input  logic        ext_lock,
  input  logic        ext_we,
  input  logic [31:0] ext_addr,
  input  logic [31:0] ext_wdata,
  output logic        ext_gnt,
  output logic        ext_done,
  output logic [31:0] ext_rdata,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_EXT  = 1'b1
  } owner_e;

  localparam logic [3:0] BurstLast = 4'(EXT_BURST - 1);

  owner_e      owner_q, owner_d;
  logic [3:0]  bcnt_q, bcnt_d;
  logic        ext_done_q, ext_done_d;
  logic [31:0] ext_rdata_q, ext_rdata_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      owner_q     <= OWN_CORE;
      bcnt_q      <= 4'd0;
      ext_done_q  <= 1'b0;
      ext_rdata_q <= 32'd0;
    end else begin
      owner_q     <= owner_d;
      bcnt_q      <= bcnt_d;
      ext_done_q  <= ext_done_d;
      ext_rdata_q <= ext_rdata_d;
    end
  end

  always_comb begin
    owner_d     = owner_q;
    bcnt_d      = bcnt_q;
    ext_done_d  = 1'b0;
    ext_rdata_d = ext_rdata_q;
    mem_we      = 1'b0;
    mem_addr    = core_addr;
    mem_wdata   = core_wdata;
    core_stall  = 1'b0;
    ext_gnt     = 1'b0;

    case (owner_q)
      OWN_CORE: begin
        mem_we = core_req & core_we;
        if (ext_req) begin
          owner_d = OWN_EXT;
          bcnt_d  = 4'd0;
        end
      end
      OWN_EXT: begin
        mem_we     = ext_req & ext_we;
        mem_addr   = ext_addr;
        mem_wdata  = ext_wdata;
        ext_gnt    = 1'b1;
        core_stall = core_req;
        if (!ext_req) begin
          owner_d = OWN_CORE;
        end else begin
          ext_done_d  = 1'b1;
          ext_rdata_d = mem_rdata;
          if (bcnt_q != 4'hF) begin
            bcnt_d = bcnt_q + 4'd1;
          end
          // The burst limit only yields to a core that is actually waiting.
          if (core_req && !ext_lock && (bcnt_q == BurstLast)) begin
            owner_d = OWN_CORE;
          end
        end
      end
      default: owner_d = OWN_CORE;
    endcase

    if (!rst) begin
      mem_we = 1'b0;
    end
  end

  assign core_rdata = mem_rdata;
  assign ext_done   = ext_done_q;
  assign ext_rdata  = ext_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a vector table plus hand-built burst,
// lock and reset sequences, all feeding one expected-output scoreboard.
module tb_dmem_arbiter;

  typedef struct {
    logic        rstN;
    logic        coreReq;
    logic        coreWe;
    logic [31:0] coreAddr;
    logic [31:0] coreWdata;
    logic        extReq;
    logic        extLock;
    logic        extWe;
    logic [31:0] extAddr;
    logic [31:0] extWdata;
  } stim_t;

  typedef struct {
    logic        gnt;
    logic        stall;
    logic        memWe;
    logic [31:0] addr;
    logic        done;
    logic [31:0] rdata;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req, core_we, core_stall;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic        ext_req, ext_lock, ext_we, ext_gnt, ext_done;
  logic [31:0] ext_addr, ext_wdata, ext_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] tbMem [0:255];
  exp_t        expQ [$];
  int          testsRun = 0;
  int          testsFailed = 0;
  vec_t        rows [13];

  always #5 clk = ~clk;

  dmem_arbiter #(.EXT_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_rdata(core_rdata), .core_stall(core_stall),
    .ext_req(ext_req), .ext_lock(ext_lock), .ext_we(ext_we), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_gnt(ext_gnt), .ext_done(ext_done), .ext_rdata(ext_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Behavioural memory: combinational read, write on the rising edge.
  assign mem_rdata = tbMem[mem_addr[7:0]];
  always @(posedge clk) begin
    if (mem_we) tbMem[mem_addr[7:0]] <= mem_wdata;
  end

  function automatic stim_t mkStim(input logic r, input logic cReq, input logic cWe,
                                   input logic [31:0] cAddr, input logic [31:0] cData,
                                   input logic eReq, input logic eLock, input logic eWe,
                                   input logic [31:0] eAddr, input logic [31:0] eData);
    stim_t s;
    s.rstN = r; s.coreReq = cReq; s.coreWe = cWe; s.coreAddr = cAddr; s.coreWdata = cData;
    s.extReq = eReq; s.extLock = eLock; s.extWe = eWe; s.extAddr = eAddr; s.extWdata = eData;
    return s;
  endfunction

  function automatic exp_t mkExp(input logic g, input logic st, input logic we,
                                 input logic [31:0] a, input logic d, input logic [31:0] rd);
    exp_t e;
    e.gnt = g; e.stall = st; e.memWe = we; e.addr = a; e.done = d; e.rdata = rd;
    return e;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    testsRun++;
    if (act !== req) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic applyStimulus(input stim_t s, input exp_t e);
    @(posedge clk);
    #1;
    rst        = s.rstN;
    core_req   = s.coreReq;
    core_we    = s.coreWe;
    core_addr  = s.coreAddr;
    core_wdata = s.coreWdata;
    ext_req    = s.extReq;
    ext_lock   = s.extLock;
    ext_we     = s.extWe;
    ext_addr   = s.extAddr;
    ext_wdata  = s.extWdata;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    @(negedge clk);
    if (expQ.size() == 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL %s: scoreboard empty, got nothing, expected an entry", tag);
      return;
    end
    e = expQ.pop_front();
    check32({tag, ".ext_gnt"},    {31'd0, ext_gnt},    {31'd0, e.gnt});
    check32({tag, ".core_stall"}, {31'd0, core_stall}, {31'd0, e.stall});
    check32({tag, ".mem_we"},     {31'd0, mem_we},     {31'd0, e.memWe});
    check32({tag, ".mem_addr"},   mem_addr,            e.addr);
    check32({tag, ".ext_done"},   {31'd0, ext_done},   {31'd0, e.done});
    check32({tag, ".ext_rdata"},  ext_rdata,           e.rdata);
    check32({tag, ".core_rdata"}, core_rdata,          tbMem[e.addr[7:0]]);
  endtask

  task automatic runCycle(input string tag, input stim_t s, input exp_t e);
    applyStimulus(s, e);
    checkOutput(tag);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) tbMem[i] = 32'd0;
    tbMem[8'h10] = 32'h12345678;
    tbMem[8'h70] = 32'h0BADF00D;
  end

  initial begin
    stim_t idle;
    logic  isCore;
    idle = mkStim(1, 0, 0, 32'h04, 32'h0, 0, 0, 0, 32'h0, 32'h0);

    rst = 1'b0; core_req = 1'b1; core_we = 1'b1; core_addr = 32'h04; core_wdata = 32'h0;
    ext_req = 1'b1; ext_lock = 1'b0; ext_we = 1'b1; ext_addr = 32'h40; ext_wdata = 32'h0;

    // Reset with both requesters active, single ext write, ext read, core write.
    rows[0]  = '{mkStim(0, 1, 1, 32'h04, 32'h0, 1, 0, 1, 32'h40, 32'hDEADBEEF), mkExp(0, 0, 0, 32'h04, 0, 32'h0)};
    rows[1]  = '{mkStim(0, 1, 1, 32'h04, 32'h0, 1, 0, 1, 32'h40, 32'hDEADBEEF), mkExp(0, 0, 0, 32'h04, 0, 32'h0)};
    rows[2]  = '{idle, mkExp(0, 0, 0, 32'h04, 0, 32'h0)};
    rows[3]  = '{mkStim(1, 0, 0, 32'h04, 32'h0, 1, 0, 1, 32'h40, 32'hDEADBEEF), mkExp(0, 0, 0, 32'h04, 0, 32'h0)};
    rows[4]  = '{mkStim(1, 0, 0, 32'h04, 32'h0, 1, 0, 1, 32'h40, 32'hDEADBEEF), mkExp(1, 0, 1, 32'h40, 0, 32'h0)};
    rows[5]  = '{mkStim(1, 0, 0, 32'h04, 32'h0, 0, 0, 1, 32'h40, 32'hDEADBEEF), mkExp(1, 0, 0, 32'h40, 1, 32'h0)};
    rows[6]  = '{idle, mkExp(0, 0, 0, 32'h04, 0, 32'h0)};
    rows[7]  = '{mkStim(1, 0, 0, 32'h04, 32'h0, 1, 0, 0, 32'h10, 32'h0), mkExp(0, 0, 0, 32'h04, 0, 32'h0)};
    rows[8]  = '{mkStim(1, 0, 0, 32'h04, 32'h0, 1, 0, 0, 32'h10, 32'h0), mkExp(1, 0, 0, 32'h10, 0, 32'h0)};
    rows[9]  = '{mkStim(1, 0, 0, 32'h04, 32'h0, 0, 0, 0, 32'h10, 32'h0), mkExp(1, 0, 0, 32'h10, 1, 32'h12345678)};
    rows[10] = '{idle, mkExp(0, 0, 0, 32'h04, 0, 32'h12345678)};
    rows[11] = '{mkStim(1, 1, 1, 32'h20, 32'hA5A5A5A5, 0, 0, 1, 32'h44, 32'h0), mkExp(0, 0, 1, 32'h20, 0, 32'h12345678)};
    rows[12] = '{idle, mkExp(0, 0, 0, 32'h04, 0, 32'h12345678)};

    for (int i = 0; i < 13; i++) begin
      runCycle($sformatf("row%0d", i), rows[i].s, rows[i].e);
    end
    check32("mem40", tbMem[8'h40], 32'hDEADBEEF);
    check32("mem20", tbMem[8'h20], 32'hA5A5A5A5);

    // Fairness: core writes 0x30, host reads 0x10; 4 granted cycles then 1 core cycle.
    for (int k = 0; k < 15; k++) begin
      isCore = ((k % 5) == 0);
      runCycle($sformatf("burst%0d", k),
               mkStim(1, 1, 1, 32'h30, 32'h11110000, 1, 0, 0, 32'h10, 32'h0),
               mkExp(!isCore, !isCore, isCore, isCore ? 32'h30 : 32'h10,
                     (k > 0) && ((k % 5) != 1), 32'h12345678));
    end
    runCycle("burstEnd0", idle, mkExp(0, 0, 0, 32'h04, 1, 32'h12345678));
    runCycle("burstEnd1", idle, mkExp(0, 0, 0, 32'h04, 0, 32'h12345678));
    check32("mem30", tbMem[8'h30], 32'h11110000);

    // Lock: 20 granted write cycles regardless of the waiting core.
    runCycle("lock0", mkStim(1, 1, 0, 32'h04, 32'h0, 1, 1, 1, 32'h50, 32'hCAFE0000),
             mkExp(0, 0, 0, 32'h04, 0, 32'h12345678));
    for (int k = 1; k <= 20; k++) begin
      runCycle($sformatf("lock%0d", k),
               mkStim(1, 1, 0, 32'h04, 32'h0, 1, 1, 1, 32'h50, 32'hCAFE0000),
               mkExp(1, 1, 1, 32'h50, k >= 2,
                     (k == 1) ? 32'h12345678 : ((k == 2) ? 32'h0 : 32'hCAFE0000)));
    end
    runCycle("lock21", mkStim(1, 0, 0, 32'h04, 32'h0, 0, 1, 1, 32'h50, 32'hCAFE0000),
             mkExp(1, 0, 0, 32'h50, 1, 32'hCAFE0000));
    runCycle("lock22", idle, mkExp(0, 0, 0, 32'h04, 0, 32'hCAFE0000));
    check32("mem50", tbMem[8'h50], 32'hCAFE0000);

    // Reset lands on the second access of a burst.
    runCycle("rstb0", mkStim(1, 0, 0, 32'h04, 32'h0, 1, 0, 1, 32'h70, 32'h77),
             mkExp(0, 0, 0, 32'h04, 0, 32'hCAFE0000));
    runCycle("rstb1", mkStim(1, 0, 0, 32'h04, 32'h0, 1, 0, 1, 32'h70, 32'h77),
             mkExp(1, 0, 1, 32'h70, 0, 32'hCAFE0000));
    runCycle("rstb2", mkStim(0, 0, 0, 32'h04, 32'h0, 1, 0, 1, 32'h70, 32'h88),
             mkExp(1, 0, 0, 32'h70, 1, 32'h0BADF00D));
    runCycle("rstb3", idle, mkExp(0, 0, 0, 32'h04, 0, 32'h0));
    runCycle("rstb4", idle, mkExp(0, 0, 0, 32'h04, 0, 32'h0));
    check32("mem70", tbMem[8'h70], 32'h77);

    check32("scoreboardLeft", 32'(expQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
